// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer (M:SS). Keypad digits shift in from the right,
// then the value counts down one second per enabled clock and stops at 0:00.
module countdown_timer (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       en,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero
);

    logic [3:0] r_mins;
    logic [3:0] r_tens;
    logic [3:0] r_ones;

    logic [3:0] w_sat;
    logic [3:0] w_dec_mins;
    logic [3:0] w_dec_tens;
    logic [3:0] w_dec_ones;
    logic       w_zero;

    assign w_sat  = (data > 4'd9) ? 4'd9 : data;
    assign w_zero = (r_mins == '0) && (r_tens == '0) && (r_ones == '0);

    // Tens digit may legally hold 6..9 after a load; borrow rules apply unchanged.
    always_comb begin
        w_dec_mins = r_mins;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != '0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != '0) begin
            w_dec_tens = r_tens - 4'd1;
            w_dec_ones = 4'd9;
        end else if (r_mins != '0) begin
            w_dec_mins = r_mins - 4'd1;
            w_dec_tens = 4'd5;
            w_dec_ones = 4'd9;
        end
    end

    always_ff @(posedge clock) begin
        if (clearn) begin
            r_mins <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else if (!loadn) begin
            r_mins <= r_tens;
            r_tens <= r_ones;
            r_ones <= w_sat;
        end else if (en && !w_zero) begin
            r_mins <= w_dec_mins;
            r_tens <= w_dec_tens;
            r_ones <= w_dec_ones;
        end
    end

    assign mins     = r_mins;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
    assign zero     = w_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: table-driven vectors plus hand-written
// multi-cycle sequences, with expected values passed through a scoreboard queue.
module tb_countdown_timer;

    logic       clock;
    logic       clearn;
    logic [3:0] data;
    logic       loadn;
    logic       en;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;

    countdown_timer u_dut (
        .clock    (clock),
        .clearn   (clearn),
        .data     (data),
        .loadn    (loadn),
        .en       (en),
        .mins     (mins),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       clr;
        logic       ldn;
        logic       ena;
        logic [3:0] d;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       z;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(input string nm, input logic c, input logic l, input logic e,
                                input logic [3:0] d, input logic [3:0] m, input logic [3:0] t,
                                input logic [3:0] o, input logic z);
        vec_t v;
        v.name = nm; v.clr = c; v.ldn = l; v.ena = e; v.d = d;
        v.m = m; v.t = t; v.o = o; v.z = z;
        return v;
    endfunction

    // Drive one vector before the edge, queue its expectation, check it after the edge.
    task automatic step(input vec_t v);
        vec_t exp_v;
        @(negedge clock);
        clearn = v.clr;
        loadn  = v.ldn;
        en     = v.ena;
        data   = v.d;
        sb.push_back(v);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            exp_v = sb.pop_front();
            n_vec++;
            if ({mins, sec_tens, sec_ones, zero} !== {exp_v.m, exp_v.t, exp_v.o, exp_v.z}) begin
                n_err++;
                $display("FAIL %s: got %h:%h%h zero=%b, expected %h:%h%h zero=%b",
                         exp_v.name, mins, sec_tens, sec_ones, zero,
                         exp_v.m, exp_v.t, exp_v.o, exp_v.z);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        clearn = 1'b0;
        loadn  = 1'b1;
        en     = 1'b0;
        data   = '0;

        // clr ldn en data -> mins tens ones zero
        vecs.push_back(mk("reset",        1, 0, 1, 4'd7,  0, 0, 0, 1));
        vecs.push_back(mk("load0_a",      0, 0, 0, 4'd0,  0, 0, 0, 1));
        vecs.push_back(mk("load0_b",      0, 0, 0, 4'd1,  0, 0, 1, 0));
        vecs.push_back(mk("load0_c",      0, 0, 0, 4'd0,  0, 1, 0, 0));
        vecs.push_back(mk("hold_en0_a",   0, 1, 0, 4'd3,  0, 1, 0, 0));
        vecs.push_back(mk("hold_en0_b",   0, 1, 0, 4'd3,  0, 1, 0, 0));
        vecs.push_back(mk("tens_borrow",  0, 1, 1, 4'd0,  0, 0, 9, 0));
        vecs.push_back(mk("clear_mid",    0, 1, 1, 4'd0,  0, 0, 8, 0));
        vecs.push_back(mk("clear_mid_b",  1, 1, 1, 4'd0,  0, 0, 0, 1));
        vecs.push_back(mk("no_resume_a",  0, 1, 1, 4'd0,  0, 0, 0, 1));
        vecs.push_back(mk("no_resume_b",  0, 1, 1, 4'd0,  0, 0, 0, 1));
        vecs.push_back(mk("min_load_a",   0, 0, 0, 4'd1,  0, 0, 1, 0));
        vecs.push_back(mk("min_load_b",   0, 0, 0, 4'd0,  0, 1, 0, 0));
        vecs.push_back(mk("min_load_c",   0, 0, 0, 4'd0,  1, 0, 0, 0));
        vecs.push_back(mk("min_borrow",   0, 1, 1, 4'd0,  0, 5, 9, 0));
        vecs.push_back(mk("l90_a",        0, 0, 0, 4'd0,  5, 9, 0, 0));
        vecs.push_back(mk("l90_b",        0, 0, 0, 4'd9,  9, 0, 9, 0));
        vecs.push_back(mk("l90_c",        0, 0, 0, 4'd0,  0, 9, 0, 0));
        vecs.push_back(mk("dec_090",      0, 1, 1, 4'd0,  0, 8, 9, 0));
        vecs.push_back(mk("l500_a",       0, 0, 0, 4'd5,  8, 9, 5, 0));
        vecs.push_back(mk("l500_b",       0, 0, 0, 4'd0,  9, 5, 0, 0));
        vecs.push_back(mk("l500_c",       0, 0, 0, 4'd0,  5, 0, 0, 0));
        vecs.push_back(mk("load_prio",    0, 0, 1, 4'd12, 0, 0, 9, 0));
        vecs.push_back(mk("en_off_hold",  0, 1, 0, 4'd0,  0, 0, 9, 0));
        vecs.push_back(mk("en_resume",    0, 1, 1, 4'd0,  0, 0, 8, 0));
        vecs.push_back(mk("sat15_a",      0, 0, 1, 4'd15, 0, 8, 9, 0));
        vecs.push_back(mk("sat10_b",      0, 0, 0, 4'd10, 8, 9, 9, 0));
        vecs.push_back(mk("load9_c",      0, 0, 0, 4'd9,  9, 9, 9, 0));
        vecs.push_back(mk("dec_999",      0, 1, 1, 4'd0,  9, 9, 8, 0));
        vecs.push_back(mk("clear_load",   1, 0, 1, 4'd5,  0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Countdown 0:10 to 0:00 then hold for 15 edges.
        step(mk("cd_load_a", 0, 0, 0, 4'd0, 0, 0, 0, 1));
        step(mk("cd_load_b", 0, 0, 0, 4'd1, 0, 0, 1, 0));
        step(mk("cd_load_c", 0, 0, 0, 4'd0, 0, 1, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            int unsigned rem;
            rem = 10 - k;
            step(mk("countdown", 0, 1, 1, 4'd0, 4'd0, 4'(rem / 10), 4'(rem % 10), rem == 0));
        end
        for (int k = 0; k < 15; k++) begin
            step(mk("stop_at_zero", 0, 1, 1, 4'd0, 0, 0, 0, 1));
        end

        // Clear mid-count from 0:07.
        step(mk("cm_load_a", 0, 0, 1, 4'd0, 0, 0, 0, 1));
        step(mk("cm_load_b", 0, 0, 1, 4'd1, 0, 0, 1, 0));
        step(mk("cm_load_c", 0, 0, 1, 4'd0, 0, 1, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            step(mk("cm_count", 0, 1, 1, 4'd0, 0, 0, 4'(10 - k), 0));
        end
        step(mk("cm_clear", 1, 1, 1, 4'd0, 0, 0, 0, 1));
        step(mk("cm_after", 0, 1, 1, 4'd0, 0, 0, 0, 1));

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
